// File: rtl/tsc_capture_if.sv
// Handshake bundle for tsc_capture_ctrl: ADC request/acknowledge, arm and send
// controls, trigger status and the serial frame output.
interface tsc_capture_if;
  logic        start;
  logic [7:0]  adc_data;
  logic        adc_rdy;
  logic        sbf;
  logic        req;
  logic        trd;
  logic [31:0] trigtm;
  logic        sd;
  logic        sd_vld;
  logic        cd;

  modport slave (
    input  start, adc_data, adc_rdy, sbf,
    output req, trd, trigtm, sd, sd_vld, cd
  );

  modport master (
    output start, adc_data, adc_rdy, sbf,
    input  req, trd, trigtm, sd, sd_vld, cd
  );
endinterface

// File: rtl/tsc_capture_ctrl.sv
// Triggered ADC capture: 32-sample ring with pre-trigger history, read out serially.
// Optional macro TSC_TIMESTAMP_HDR_EN prefixes the frame with the 32-bit trigger timestamp.
module tsc_capture_ctrl #(
  parameter logic [7:0] TRIGVL = 8'hD5,
  parameter int         PRE    = 16,
  parameter int         SDIV   = 4
) (
  input logic          clk,
  input logic          reset,
  tsc_capture_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, PREFILL, ARMED, POST, HOLD, SEND, DONE
  } state_e;

  localparam int            DW        = $clog2(SDIV + 1);
  localparam logic [DW-1:0] DIV_MAX   = DW'(SDIV);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [4:0]    PRE_LAST  = 5'(PRE - 1);
  localparam logic [4:0]    POST_LAST = 5'(30 - PRE);
`ifdef TSC_TIMESTAMP_HDR_EN
  localparam int            FW         = 9;
  localparam logic [8:0]    FRAME_BITS = 9'd288;
`else
  localparam int            FW         = 8;
  localparam logic [8:0]    FRAME_BITS = 9'd256;
`endif

  state_e        state_q;
  logic          req_q;
  logic          trd_q;
  logic          sd_q;
  logic          sd_vld_q;
  logic          cd_q;
  logic [31:0]   timer_q;
  logic [31:0]   trigtm_q;
  logic [4:0]    wr_ptr_q;
  logic [4:0]    cnt_q;
  logic [DW-1:0] div_q;
  logic [8:0]    bit_q;
  logic [7:0]    ring_q [32];

  logic          capturing;
  logic          accept;
  logic          hit;

  assign capturing = (state_q == PREFILL) || (state_q == ARMED) || (state_q == POST);
  assign accept    = capturing && req_q && bus.adc_rdy;
  assign hit       = (bus.adc_data >= TRIGVL);

  // Frame bit addressing: bit_q is the index of the next bit to place on sd.
  logic [FW-1:0] frame_idx;
  logic [7:0]    ring_idx;
  logic [4:0]    rd_ptr;
  logic [7:0]    rd_byte;
  logic          next_bit;

  // NOTE: every variable written here gets a default first, so no path infers a latch.
  always_comb begin
    frame_idx = bit_q[FW-1:0];
`ifdef TSC_TIMESTAMP_HDR_EN
    ring_idx  = frame_idx[7:0] - 8'd32;
`else
    ring_idx  = frame_idx;
`endif
    rd_ptr    = wr_ptr_q + ring_idx[7:3];
    rd_byte   = ring_q[rd_ptr];
    next_bit  = rd_byte[3'd7 - ring_idx[2:0]];
`ifdef TSC_TIMESTAMP_HDR_EN
    if (frame_idx < 9'd32) begin
      next_bit = trigtm_q[5'd31 - frame_idx[4:0]];
    end
`endif
  end

  // NOTE: sample storage carries no reset; it is only read after a full capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      ring_q[wr_ptr_q] <= bus.adc_data;
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      trd_q    <= 1'b0;
      sd_q     <= 1'b0;
      sd_vld_q <= 1'b0;
      cd_q     <= 1'b0;
      timer_q  <= '0;
      trigtm_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
    end else begin
      timer_q <= timer_q + 32'd1;
      cd_q    <= 1'b0;

      if (accept) begin
        wr_ptr_q <= wr_ptr_q + 5'd1;
      end

      // Request pacing: a new rise needs SDIV cycles since the previous rise.
      if (capturing) begin
        if (div_q != DIV_MAX) begin
          div_q <= div_q + DIV_ONE;
        end
        if (accept) begin
          req_q <= 1'b0;
        end else if (!req_q && (div_q == DIV_MAX)) begin
          req_q <= 1'b1;
          div_q <= DIV_ONE;
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q  <= PREFILL;
            timer_q  <= '0;
            trigtm_q <= '0;
            req_q    <= 1'b1;
            div_q    <= DIV_ONE;
            cnt_q    <= '0;
            bit_q    <= '0;
          end
        end

        PREFILL: begin
          if (accept) begin
            if (cnt_q == PRE_LAST) begin
              state_q <= ARMED;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end

        ARMED: begin
          if (accept && hit) begin
            trd_q    <= 1'b1;
            trigtm_q <= timer_q;
            cnt_q    <= '0;
            if (PRE < 31) begin
              state_q <= POST;
            end else begin
              state_q <= HOLD;
            end
          end
        end

        POST: begin
          if (accept) begin
            if (cnt_q == POST_LAST) begin
              state_q <= HOLD;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end

        HOLD: begin
          if (bus.sbf) begin
            state_q  <= SEND;
            sd_q     <= next_bit;
            sd_vld_q <= 1'b1;
            bit_q    <= 9'd1;
          end
        end

        SEND: begin
          if (bit_q == FRAME_BITS) begin
            state_q  <= DONE;
            sd_q     <= 1'b0;
            sd_vld_q <= 1'b0;
            cd_q     <= 1'b1;
            trd_q    <= 1'b0;
            bit_q    <= '0;
          end else begin
            sd_q  <= next_bit;
            bit_q <= bit_q + 9'd1;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req    = req_q;
  assign bus.trd    = trd_q;
  assign bus.trigtm = trigtm_q;
  assign bus.sd     = sd_q;
  assign bus.sd_vld = sd_vld_q;
  assign bus.cd     = cd_q;

endmodule

// File: tb/tb_tsc_capture_ctrl.sv
// Scoreboard bench for tsc_capture_ctrl: stimulus pushes expected trigger stamps and
// frame bytes; a negedge monitor pops and compares whatever the DUT presents.
module tb_tsc_capture_ctrl;
  localparam int         PRE  = 16;
  localparam logic [7:0] TRIG = 8'hD5;
`ifdef TSC_TIMESTAMP_HDR_EN
  localparam int FRAME_BITS = 288;
  localparam int HDR_BYTES  = 4;
`else
  localparam int FRAME_BITS = 256;
  localparam int HDR_BYTES  = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tsc_capture_if bus ();

  tsc_capture_ctrl #(.TRIGVL(TRIG), .PRE(PRE), .SDIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // scoreboard queues
  logic [7:0]  exp_bytes [$];
  logic [31:0] exp_trig  [$];
  int          exp_len   [$];
  logic [7:0]  rx_bytes  [$];
  int          mon_cnt   = 0;
  int          done_cnt  = 0;
  logic [7:0]  mon_byte  = 8'd0;
  logic        trd_prev  = 1'b0;

  // ADC stimulus model state
  logic [7:0]  tbl [64];
  logic [7:0]  hist [$];
  int          cyc = 0, start_cyc = 0, n_acc = 0, wait_cnt = 0;
  int          req_hi = 0, stall_idx = -1, stall_hi = 0;
  bit          trig_seen = 1'b0, stray_armed = 1'b0;
  logic [31:0] model_trigtm = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
  endtask

  // ADC: acks one cycle after seeing req (10 for the stalled sample), can inject a stray ack.
  task automatic adc_model();
    int         delay;
    logic [7:0] v;
    delay = (n_acc == stall_idx) ? 10 : 1;
    if (bus.req && !bus.adc_rdy) begin
      req_hi++;
      if (wait_cnt >= delay) begin
        v = (n_acc < 64) ? tbl[n_acc[5:0]] : 8'h99;
        bus.adc_rdy  = 1'b1;
        bus.adc_data = v;
        hist.push_back(v);
        if (!trig_seen && n_acc >= PRE && v >= TRIG) begin
          trig_seen    = 1'b1;
          model_trigtm = 32'(cyc - start_cyc - 1);
          exp_trig.push_back(model_trigtm);
        end
        if (n_acc == stall_idx) stall_hi = req_hi;
        n_acc++;
        req_hi   = 0;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      bus.adc_rdy = 1'b0;
      if (stray_armed && !bus.req) begin
        bus.adc_rdy  = 1'b1;
        bus.adc_data = 8'hEE;
        stray_armed  = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    adc_model();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon_cnt  = 0;
      trd_prev = 1'b0;
      rx_bytes.delete();
    end else begin
      if (bus.sd_vld) begin
        mon_byte = {mon_byte[6:0], bus.sd};
        mon_cnt++;
        if (mon_cnt % 8 == 0) begin
          rx_bytes.push_back(mon_byte);
          if (exp_bytes.size() == 0) unexpected("frame_byte_extra");
          else check("frame_byte", 32'(mon_byte), 32'(exp_bytes.pop_front()));
        end
      end else begin
        check("sd_idle_zero", 32'(bus.sd), 32'd0);
      end
      if (bus.trd && !trd_prev) begin
        if (exp_trig.size() == 0) unexpected("trd_rise_unexpected");
        else check("trigtm", bus.trigtm, exp_trig.pop_front());
      end
      if (bus.cd) begin
        check("cd_trd_clear", 32'(bus.trd), 32'd0);
        if (exp_len.size() == 0) unexpected("cd_unexpected");
        else check("frame_len", 32'(mon_cnt), 32'(exp_len.pop_front()));
        mon_cnt = 0;
        done_cnt++;
      end
      trd_prev = bus.trd;
    end
  end

  task automatic run_capture(input int total, input bit poke);
    bit poke_done;
    poke_done = 1'b0;
    hist.delete();
    n_acc = 0; trig_seen = 1'b0; wait_cnt = 0; req_hi = 0; stall_hi = 0;
    bus.start = 1'b1;
    start_cyc = cyc;
    step();
    bus.start   = 1'b0;
    stray_armed = poke;
    for (int i = 0; i < 3000 && n_acc < total; i++) begin
      if (poke && n_acc == 18 && !poke_done) begin
        bus.start = 1'b1;
        bus.sbf   = 1'b1;
        poke_done = 1'b1;
      end else begin
        bus.start = 1'b0;
        bus.sbf   = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
    bus.sbf   = 1'b0;
    repeat (40) step();
    check("capture_sample_count", 32'(n_acc), 32'(total));
    check("hold_req_low", 32'(bus.req), 32'd0);
    check("hold_trd_high", 32'(bus.trd), 32'd1);
    check("trigger_consumed", 32'(exp_trig.size()), 32'd0);
    if (poke) check("stall_req_cycles", 32'(stall_hi), 32'd11);
  endtask

  task automatic send_prep();
    rx_bytes.delete();
`ifdef TSC_TIMESTAMP_HDR_EN
    for (int b = 3; b >= 0; b--) exp_bytes.push_back(model_trigtm[b*8 +: 8]);
`endif
    for (int i = hist.size() - 32; i < hist.size(); i++) exp_bytes.push_back(hist[i]);
    exp_len.push_back(FRAME_BITS);
    bus.sbf = 1'b1;
    step();
    bus.sbf = 1'b0;
  endtask

  task automatic send_full(input logic [7:0] oldest);
    int d0;
    d0 = done_cnt;
    send_prep();
    for (int i = 0; i < 600 && done_cnt == d0; i++) step();
    if (done_cnt == d0) unexpected("send_timeout");
    step();
    check("cd_one_cycle", 32'(bus.cd), 32'd0);
    check("idle_sd_vld", 32'(bus.sd_vld), 32'd0);
    check("frame_consumed", 32'(exp_bytes.size()), 32'd0);
    if (rx_bytes.size() > HDR_BYTES + PRE) begin
      check("first_byte_oldest", 32'(rx_bytes[HDR_BYTES]), 32'(oldest));
      check("byte_pre_trigger", 32'(rx_bytes[HDR_BYTES + PRE]), 32'h0000_00D5);
    end else begin
      unexpected("frame_too_short");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.sbf = 1'b0; bus.adc_rdy = 1'b0; bus.adc_data = 8'h00;
    repeat (3) step();
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_trd", 32'(bus.trd), 32'd0);
    check("rst_trigtm", bus.trigtm, 32'd0);
    check("rst_sd", 32'(bus.sd), 32'd0);
    check("rst_sd_vld", 32'(bus.sd_vld), 32'd0);
    check("rst_cd", 32'(bus.cd), 32'd0);
    reset = 1'b0;
    step();

    // sbf outside HOLD does nothing
    bus.sbf = 1'b1; step(); bus.sbf = 1'b0;
    repeat (4) step();
    check("idle_sbf_ignored", 32'(bus.sd_vld), 32'd0);

    // capture 1: ramp, 0xFF in prefill, 0xD4 armed (no trigger), 0xD5 at sample 20
    for (int i = 0; i < 64; i++) tbl[i] = 8'(16 + i);
    tbl[3] = 8'hFF; tbl[17] = 8'hD4; tbl[20] = 8'hD5;
    stall_idx = 5;
    run_capture(36, 1'b1);
    stall_idx = -1;
    send_full(8'h14);

    // capture 2: 0xD5 as last prefill sample is ignored, first armed sample triggers
    for (int i = 0; i < 64; i++) tbl[i] = 8'(64 + i);
    tbl[15] = 8'hD5; tbl[16] = 8'hD6;
    run_capture(32, 1'b0);
    send_prep();
    for (int i = 0; i < 300 && mon_cnt < 100; i++) step();
    check("abort_bit_reached", 32'(mon_cnt >= 100), 32'd1);
    reset = 1'b1;
    step();
    check("abort_req", 32'(bus.req), 32'd0);
    check("abort_trd", 32'(bus.trd), 32'd0);
    check("abort_trigtm", bus.trigtm, 32'd0);
    check("abort_sd", 32'(bus.sd), 32'd0);
    check("abort_sd_vld", 32'(bus.sd_vld), 32'd0);
    check("abort_cd", 32'(bus.cd), 32'd0);
    step();
    reset = 1'b0;
    exp_bytes.delete();
    exp_len.delete();
    repeat (5) step();
    check("post_reset_quiet", 32'(bus.sd_vld), 32'd0);

    // capture 3 after reset: 41 samples wrap the ring, trigger at sample 25
    for (int i = 0; i < 64; i++) tbl[i] = 8'(96 + i);
    tbl[25] = 8'hD5;
    run_capture(41, 1'b0);
    send_full(8'h69);

    check("no_pending_trigger", 32'(exp_trig.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
